// File: rtl/ram_arbiter_pkg.sv
// Shared constants for the two-master RAM port A arbiter: requester indices,
// byte-enable width and the contention policy selector.
package ram_arbiter_pkg;

    localparam logic        REQ_M0   = 1'b0;
    localparam logic        REQ_M1   = 1'b1;
    localparam int unsigned BE_WIDTH = 4;

    typedef enum logic {
        ARB_FIXED,
        ARB_ROUND_ROBIN
    } arb_policy_e;

endpackage

// File: rtl/rr_select.sv
// Two-way grant pick from request pair, previous winner and lock state.
module rr_select
    import ram_arbiter_pkg::*;
#(
    parameter arb_policy_e POLICY = ARB_FIXED
) (
    input  logic [1:0] req,
    input  logic       last_winner,
    input  logic       locked,
    output logic [1:0] gnt,
    output logic       winner
);

    always_comb begin
        gnt    = '0;
        winner = last_winner;
        if (locked && req[last_winner]) begin
            // Previous owner held its lock and is still asking: it keeps the port.
            winner           = last_winner;
            gnt[last_winner] = 1'b1;
        end else if (&req) begin
            winner      = (POLICY == ARB_ROUND_ROBIN) ? ~last_winner : REQ_M0;
            gnt[winner] = 1'b1;
        end else if (req[REQ_M0]) begin
            winner      = REQ_M0;
            gnt[REQ_M0] = 1'b1;
        end else if (req[REQ_M1]) begin
            winner      = REQ_M1;
            gnt[REQ_M1] = 1'b1;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates two masters onto RAM port A with lock support and 1-cycle read return.
// Define RAM_ARB_ROUND_ROBIN_EN for round-robin contention; default is fixed m0 priority.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     m0_req,
    input  logic                     m0_lock,
    input  logic [BE_WIDTH-1:0]      m0_we,
    input  logic [ADDRESS_WIDTH-1:2] m0_addr,
    input  logic [31:0]              m0_wdata,
    output logic                     m0_gnt,
    output logic                     m0_rvalid,
    output logic [31:0]              m0_rdata,
    input  logic                     m1_req,
    input  logic                     m1_lock,
    input  logic [BE_WIDTH-1:0]      m1_we,
    input  logic [ADDRESS_WIDTH-1:2] m1_addr,
    input  logic [31:0]              m1_wdata,
    output logic                     m1_gnt,
    output logic                     m1_rvalid,
    output logic [31:0]              m1_rdata,
    output logic [BE_WIDTH-1:0]      ram_we,
    output logic [ADDRESS_WIDTH-1:2] ram_addr,
    output logic [31:0]              ram_data,
    input  logic [31:0]              ram_q
);

`ifdef RAM_ARB_ROUND_ROBIN_EN
    localparam arb_policy_e POLICY = ARB_ROUND_ROBIN;
`else
    localparam arb_policy_e POLICY = ARB_FIXED;
`endif

    logic [1:0] req;
    logic [1:0] gnt_pick;
    logic [1:0] gnt;
    logic [1:0] rd_accept;
    logic [1:0] rd_pend;
    logic       winner;
    logic       last_winner;
    logic       locked;

    assign req = {m1_req, m0_req};

    rr_select #(.POLICY(POLICY)) u_select (
        .req         (req),
        .last_winner (last_winner),
        .locked      (locked),
        .gnt         (gnt_pick),
        .winner      (winner)
    );

    assign gnt    = reset ? '0 : gnt_pick;
    assign m0_gnt = gnt[REQ_M0];
    assign m1_gnt = gnt[REQ_M1];

    always_comb begin
        ram_we   = '0;
        ram_addr = m0_addr;
        ram_data = m0_wdata;
        if (gnt[REQ_M1]) begin
            ram_we   = m1_we;
            ram_addr = m1_addr;
            ram_data = m1_wdata;
        end else if (gnt[REQ_M0]) begin
            ram_we   = m0_we;
        end
    end

    assign rd_accept = {gnt[REQ_M1] & ~(|m1_we), gnt[REQ_M0] & ~(|m0_we)};

    always_ff @(posedge clk) begin
        if (reset) begin
            last_winner <= REQ_M1;
            locked      <= 1'b0;
            rd_pend     <= '0;
        end else begin
            rd_pend <= rd_accept;
            if (|gnt) begin
                last_winner <= winner;
                locked      <= (winner == REQ_M1) ? m1_lock : m0_lock;
            end else begin
                locked <= 1'b0;
            end
        end
    end

    // Masked by reset so a read accepted just before reset never returns.
    assign m0_rvalid = rd_pend[REQ_M0] & ~reset;
    assign m1_rvalid = rd_pend[REQ_M1] & ~reset;
    assign m0_rdata  = ram_q;
    assign m1_rdata  = ram_q;

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 16, meaning byte-address width of the shared RAM port A.
REQ-002 SHALL have ports `clk` (in, 1, sole clock) and `reset` (in, 1, synchronous, active-high).
REQ-003 SHALL have ports mN_req (in, 1, access request), with N=0,1.
REQ-004 SHALL have ports mN_lock (in, 1, hold grant for back-to-back accesses).
REQ-005 SHALL have ports mN_we (in, 4, byte write enables, 0 = read).
REQ-006 SHALL have ports mN_addr (in, [ADDRESS_WIDTH-1:2], word address).
REQ-007 SHALL have ports mN_wdata (in, 32, write data).
REQ-008 SHALL have ports mN_gnt (out, 1, request accepted this cycle).
REQ-009 SHALL have ports mN_rvalid (out, 1, read data valid).
REQ-010 SHALL have ports mN_rdata (out, 32, read data).
REQ-011 SHALL have ports ram_we (out, 4), ram_addr (out, [ADDRESS_WIDTH-1:2]) and ram_data (out, 32), driving RAM port A.
REQ-012 SHALL have port ram_q (in, 32), the RAM port A registered read data, 1-cycle latency.

Function
REQ-013 SHALL arbitrate combinationally each cycle: at most one of m0_gnt/m1_gnt high; a gnt SHALL only be high while the matching req is high.
REQ-014 On grant, ram_we/ram_addr/ram_data SHALL carry the winner's we/addr/wdata in the same cycle; with no grant, ram_we SHALL be 4'b0000.
REQ-015 Every accepted request (req&gnt) SHALL be one complete transaction; one transaction per cycle throughput.
REQ-016 Accepted read (we==0) SHALL raise that requester's rvalid exactly one cycle later, with rdata = ram_q in that cycle.
REQ-017 Accepted write SHALL complete at grant; it SHALL produce no rvalid.
REQ-018 rvalid of the non-owner SHALL stay 0; rdata SHALL be don't-care while rvalid is 0.
REQ-019 Lock: if the previous-cycle winner had lock=1 and still has req=1, it SHALL win again regardless of the other requester.
REQ-020 Lock SHALL be released when the holder drops req or lock; arbitration SHALL then resume per REQ-025/026.
REQ-021 State: registered last_winner (1 bit) and locked flag; locked = winner's lock at grant time, cleared when no grant occurs.
REQ-022 Simultaneous req with no lock held SHALL be resolved by the policy in Configuration.
REQ-023 Lone requester SHALL be granted in the same cycle it asserts req, with no idle bubble.

Reset
REQ-024 While reset=1: gnt outputs 0, rvalid outputs 0, ram_we 0, locked cleared, last_winner=1 (so m0 wins first); a read accepted the cycle before reset asserts SHALL NOT produce rvalid.

Configuration
REQ-025 With RAM_ARB_ROUND_ROBIN_EN defined: on contention the requester other than last_winner SHALL win.
REQ-026 Without RAM_ARB_ROUND_ROBIN_EN: fixed priority, m0 always wins contention (lock still honoured); last_winner still tracked.

Structure
REQ-027 Shared package SHALL hold the requester-index constants (REQ_M0=0, REQ_M1=1) and the byte-enable width constant (4).
REQ-028 Sub-module `rr_select` (2-way priority pick from req, last_winner, lock state) SHALL be instantiated; all other logic is flat.

Verification
REQ-029 Bench: reset, m0 reads addr 0x0010 (RAM preloaded 0xDEADBEEF) -> m0_gnt same cycle, m0_rvalid next cycle with 0xDEADBEEF, m1_rvalid 0.
REQ-030 Bench: m0 and m1 both req every cycle, no lock, RR macro on -> grants alternate m0,m1,m0,m1; macro off -> m0 granted every cycle, m1 never.
REQ-031 Bench: m1 lock=1 for 4 reads at 0x20..0x23 while m0 req continuously -> m1 granted 4 consecutive cycles, then m0 granted on the cycle m1 drops lock.
REQ-032 Bench: m1 writes we=4'b0011 data 0x12345678 to 0x0040, m0 then reads 0x0040 (old value 0xAAAAAAAA) -> rdata 0xAAAA5678, no rvalid for the write.
REQ-033 Bench: reset asserted the cycle after a granted m0 read -> m0_rvalid stays 0; after release the first contention goes to m0.
